// File: rtl/image_pkg.sv
// Shared frame geometry and sequencer state encoding for the row-parallel
// threshold filter datapath.
package image_pkg;

  localparam int unsigned COL     = 256;
  localparam int unsigned ROW     = 256;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned PIX_W   = 3 * WIDTH;
  localparam int unsigned ROW_W   = COL * PIX_W;
  localparam int unsigned FLT_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/row_pack_unpack.sv
// Row register with a slot-indexed pixel write, a whole-row load and a
// slot-indexed pixel read. Slot 0 sits at the MSB end of the row.
module row_pack_unpack #(
  parameter int unsigned COL    = image_pkg::COL,
  parameter int unsigned PIX_W  = image_pkg::PIX_W,
  parameter int unsigned SLOT_W = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [SLOT_W-1:0]      i_wr_slot,
  input  logic [PIX_W-1:0]       i_wr_pix,
  input  logic                   i_ld_en,
  input  logic [COL*PIX_W-1:0]   i_ld_row,
  input  logic [SLOT_W-1:0]      i_rd_slot,
  output logic [COL*PIX_W-1:0]   o_row,
  output logic [PIX_W-1:0]       o_rd_pix
);

  localparam int unsigned ROW_W = COL * PIX_W;

  logic [ROW_W-1:0] r_row;

  // Whole-row load takes priority over a single-slot write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if (i_ld_en) begin
      r_row <= i_ld_row;
    end else if (i_wr_en) begin
      for (int s = 0; s < COL; s++) begin
        if (i_wr_slot == SLOT_W'(s)) begin
          r_row[ROW_W-1-s*PIX_W -: PIX_W] <= i_wr_pix;
        end
      end
    end
  end

  always_comb begin
    o_rd_pix = '0;
    for (int s = 0; s < COL; s++) begin
      if (i_rd_slot == SLOT_W'(s)) begin
        o_rd_pix = r_row[ROW_W-1-s*PIX_W -: PIX_W];
      end
    end
  end

  assign o_row = r_row;

endmodule

// File: rtl/row_stream_sequencer.sv
// Packs a pixel stream into row words, runs each row through the external
// threshold filter and re-serialises the filtered row, ROW times per frame.
module row_stream_sequencer #(
  parameter int unsigned COL     = image_pkg::COL,
  parameter int unsigned ROW     = image_pkg::ROW,
  parameter int unsigned WIDTH   = image_pkg::WIDTH,
  parameter int unsigned FLT_LAT = image_pkg::FLT_LAT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [3*WIDTH-1:0]         pix_in,
  input  logic                       pix_in_valid,
  output logic                       pix_in_ready,
  output logic [COL*3*WIDTH-1:0]     flt_row_in,
  output logic                       flt_set,
  input  logic [COL*3*WIDTH-1:0]     flt_row_out,
  output logic [3*WIDTH-1:0]         pix_out,
  output logic                       pix_out_valid,
  input  logic                       pix_out_ready,
  output logic                       busy,
  output logic [$clog2(ROW)-1:0]     row_cnt,
  output logic                       frame_done
);

  import image_pkg::*;

  localparam int unsigned PW     = 3 * WIDTH;
  localparam int unsigned RW     = COL * PW;
  localparam int unsigned COL_W  = (COL > 1) ? $clog2(COL) : 1;
  localparam int unsigned ROW_CW = $clog2(ROW);
  localparam int unsigned WAIT_W = 4;

  state_t r_state;
  state_t w_next;

  logic [COL_W-1:0]  r_col;
  logic [ROW_CW-1:0] r_row_cnt;
  logic [WAIT_W-1:0] r_wait;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_wait_last;
  logic          w_capture;
  logic [PW-1:0] w_out_pix;
  logic [PW-1:0] w_in_pix_unused;
  logic [RW-1:0] w_out_row_unused;

  assign w_in_xfer   = pix_in_valid && pix_in_ready;
  assign w_out_xfer  = pix_out_valid && pix_out_ready;
  assign w_col_last  = (r_col == COL_W'(COL - 1));
  assign w_row_last  = (r_row_cnt == ROW_CW'(ROW - 1));
  assign w_wait_last = (r_wait == WAIT_W'(FLT_LAT - 1));
  assign w_capture   = (r_state == CAPTURE);
  assign row_cnt     = r_row_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FILL;
      FILL:    if (w_in_xfer && w_col_last) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_wait_last) w_next = CAPTURE;
      CAPTURE: w_next = DRAIN;
      DRAIN:   if (w_out_xfer && w_col_last) w_next = w_row_last ? DONE : FILL;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pix_in_ready  = 1'b0;
    flt_set       = 1'b0;
    pix_out_valid = 1'b0;
    pix_out       = '0;
    busy          = 1'b1;
    frame_done    = 1'b0;
    case (r_state)
      IDLE:    busy = 1'b0;
      FILL:    pix_in_ready = 1'b1;
      ISSUE:   flt_set = 1'b1;
      DRAIN: begin
        pix_out_valid = 1'b1;
        pix_out       = w_out_pix;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // Column, row and filter-wait counters; every terminal compare is exact.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_col     <= '0;
      r_row_cnt <= '0;
      r_wait    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_col     <= '0;
            r_row_cnt <= '0;
          end
        end
        FILL: begin
          if (w_in_xfer) r_col <= w_col_last ? '0 : r_col + 1'b1;
        end
        ISSUE: r_wait <= '0;
        WAIT: begin
          if (!w_wait_last) r_wait <= r_wait + 1'b1;
        end
        DRAIN: begin
          if (w_out_xfer) begin
            if (w_col_last) begin
              r_col <= '0;
              if (!w_row_last) r_row_cnt <= r_row_cnt + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        DONE: r_row_cnt <= '0;
        default: ;
      endcase
    end
  end

  row_pack_unpack #(
    .COL    (COL),
    .PIX_W  (PW),
    .SLOT_W (COL_W)
  ) u_in_row (
    .clk       (CLK),
    .rst_n     (RST),
    .i_wr_en   (w_in_xfer),
    .i_wr_slot (r_col),
    .i_wr_pix  (pix_in),
    .i_ld_en   (1'b0),
    .i_ld_row  ('0),
    .i_rd_slot (r_col),
    .o_row     (flt_row_in),
    .o_rd_pix  (w_in_pix_unused)
  );

  // Output side: whole filtered row is loaded in CAPTURE, then read slot by slot.
  row_pack_unpack #(
    .COL    (COL),
    .PIX_W  (PW),
    .SLOT_W (COL_W)
  ) u_out_row (
    .clk       (CLK),
    .rst_n     (RST),
    .i_wr_en   (1'b0),
    .i_wr_slot ('0),
    .i_wr_pix  ('0),
    .i_ld_en   (w_capture),
    .i_ld_row  (flt_row_out),
    .i_rd_slot (r_col),
    .o_row     (w_out_row_unused),
    .o_rd_pix  (w_out_pix)
  );

endmodule
